x68k_video_timing_gen: RTL and testbench
========================================

Name: x68k_video_timing_gen

Overview:
- Parametrised raster timing generator for the X68000 video path; the successor to the fixed-width sync block.
- Produces a fractional pixel clock-enable from gclk using a numerator/denominator pair.
- Counts dots, characters and lines; generates sync, blank, DE, line-buffer ping-pong addressing, interlace field, doublescan line mapping and the raster interrupt.
- Timing registers are shadowed and applied only at frame boundaries, so CRTC writes mid-frame never tear the raster.

Parameters:
- HC_W, 8, character-counter width (htotal/hsynl/hvbgn/hvend width).
- VC_W, 10, line-counter width (vtotal/vsynl/vvbgn/vvend/rint width).
- DOT_LOG2, 3, log2 dots per character.
- ACC_W, 24, fractional accumulator width; ce_inc and ce_mod are ACC_W bits.
- LB_AW, 10, line-buffer address width; must be ≥ DOT_LOG2+1.

Ports:
- gclk  in  1  system clock
- rstn  in  1  synchronous active-low reset
- ce_inc  in  ACC_W  accumulator increment per gclk
- ce_mod  in  ACC_W  accumulator modulus; requires ce_mod > ce_inc > 0
- htotal, hsynl, hvbgn, hvend  in  HC_W each  horizontal timing, in characters
- vtotal, vsynl, vvbgn, vvend  in  VC_W each  vertical timing, in lines
- rint  in  VC_W  raster-interrupt line
- interlace  in  1  interlace mode enable
- dscan  in  1  doublescan mode enable
- pix_ce  out  1  pixel clock enable
- hsync, vsync, hblank, vblank, de  out  1 each  raster signals; de = ~hblank & ~vblank
- hcomp, vcomp  out  1 each  single-gclk pulses at line start and frame start
- field  out  1  current interlace field
- lbuf_sel  out  1  line-buffer bank being displayed
- lbuf_addr  out  LB_AW  display read address
- src_line  out  VC_W  source line to render (vcnt, or vcnt>>1 in doublescan)
- rint_irq  out  1  single-gclk raster-interrupt pulse

Behaviour:
- Reset (rstn=0 at a gclk edge): acc, dot, hcnt, vcnt, field, lbuf_addr, src_line = 0.
  - hblank = vblank = lbuf_sel = 1.
  - hsync, vsync, de, hcomp, vcomp, rint_irq, pix_ce = 0.
  - Shadow timing registers load directly from the inputs.
  - Reset asserted mid-line aborts the line immediately; no partial pulses are emitted.
- CE generator, every gclk:
  - If acc + ce_inc ≥ ce_mod: acc ← acc + ce_inc − ce_mod and pix_ce = 1 (registered).
  - Otherwise: acc ← acc + ce_inc and pix_ce = 0.
  - Sum is computed ACC_W+1 bits wide; no overflow is allowed.
  - pix_ce is never high on two consecutive gclk while ce_inc < ce_mod/2.
- Counters advance only on pix_ce:
  - dot increments and wraps at 2^DOT_LOG2−1.
  - On dot wrap: hcnt increments; if hcnt == htotal_s then hcnt ← 0 (line end).
  - At line end: vcnt increments; if vcnt == vlast then vcnt ← 0 (frame end).
  - vlast = vtotal_s, or vtotal_s+1 when interlace_s and field == 0.
  - At frame end: field toggles when interlace_s=1, else field is held 0.
- Shadow update: all timing inputs plus interlace/dscan are copied into shadows on the same pix_ce as frame end, so new values take effect from line 0.
- Decodes use shadow values, are registered, and appear 1 gclk after the pix_ce that moved the counters:
  - hsync = hcnt < hsynl_s.
  - vsync = vcnt < vsynl_s.
  - hblank = ~(hvbgn_s ≤ hcnt < hvend_s).
  - vblank = ~(vvbgn_s ≤ vcnt < vvend_s).
- hcomp is high for 1 gclk after each line end; vcomp is high for 1 gclk after each frame end and coincides with that hcomp.
- rint_irq pulses 1 gclk together with hcomp when the new vcnt == rint_s; it fires once per frame (once per field when interlaced).
- Line buffer:
  - lbuf_addr = {char_index, dot}, where char_index counts characters since hblank fell; it holds 0 while hblank=1.
  - Width is truncated to LB_AW.
  - lbuf_sel toggles at each line end. With dscan_s=1 it toggles only when the new vcnt is even, so each source line is displayed twice.
- src_line = vcnt, or vcnt>>1 when dscan_s=1; it updates with hcomp.
- Degenerate timing: if hvbgn_s ≥ hvend_s, hblank stays 1; if vvbgn_s ≥ vvend_s, vblank stays 1. This is never X and never wraps.

Test Plan:
- ce_inc=12500, ce_mod=28755 over 28755 gclk → exactly 12500 pix_ce pulses, with no back-to-back pulses.
- htotal=3, vtotal=2, all blanks/syncs 0, ce every gclk → hcomp every 32 gclk, vcomp every 96 gclk; hcnt sequence 0..3, vcnt sequence 0..2.
- hsynl=2, hvbgn=1, hvend=3, htotal=4 → hsync high for chars 0–1, de high for chars 1–2 only; lbuf_addr runs 0..15 then returns to 0.
- interlace=1, vtotal=4 → field-0 frames have 6 lines and field-1 frames have 5; field alternates; rint=2 gives one irq per field.
- dscan=1 → src_line reads 0,0,1,1,2,2…; lbuf_sel toggles every 2 lines.
- Change htotal from 7 to 3 mid-frame → the old line length holds until vcomp, then 4-char lines begin at line 0. Assert rstn=0 mid-line → every output takes its reset value on the next edge.

Source files
------------

// File: rtl/x68k_video_timing_gen_if.sv
// Raster timing bundle: CRTC timing registers in, raster/line-buffer controls out.
// master = CRTC/consumer side, slave = the timing generator.
interface x68k_video_timing_gen_if #(
  parameter int HC_W  = 8,
  parameter int VC_W  = 10,
  parameter int ACC_W = 24,
  parameter int LB_AW = 10
) ();
  logic [ACC_W-1:0] ce_inc, ce_mod;
  logic [HC_W-1:0]  htotal, hsynl, hvbgn, hvend;
  logic [VC_W-1:0]  vtotal, vsynl, vvbgn, vvend, rint;
  logic             interlace, dscan;
  logic             pix_ce, hsync, vsync, hblank, vblank, de, hcomp, vcomp;
  logic             field, lbuf_sel, rint_irq;
  logic [LB_AW-1:0] lbuf_addr;
  logic [VC_W-1:0]  src_line;

  modport master (
    output ce_inc, ce_mod, htotal, hsynl, hvbgn, hvend,
           vtotal, vsynl, vvbgn, vvend, rint, interlace, dscan,
    input  pix_ce, hsync, vsync, hblank, vblank, de, hcomp, vcomp,
           field, lbuf_sel, rint_irq, lbuf_addr, src_line
  );
  modport slave (
    input  ce_inc, ce_mod, htotal, hsynl, hvbgn, hvend,
           vtotal, vsynl, vvbgn, vvend, rint, interlace, dscan,
    output pix_ce, hsync, vsync, hblank, vblank, de, hcomp, vcomp,
           field, lbuf_sel, rint_irq, lbuf_addr, src_line
  );
endinterface

// File: rtl/x68k_video_timing_gen.sv
// X68000 raster timing generator: fractional pixel CE, dot/char/line counters,
// frame-boundary shadowed timing, sync/blank/DE, line-buffer addressing, raster IRQ.
module x68k_video_timing_gen #(
  parameter int HC_W     = 8,
  parameter int VC_W     = 10,
  parameter int DOT_LOG2 = 3,
  parameter int ACC_W    = 24,
  parameter int LB_AW    = 10
) (
  input  logic                  gclk,
  input  logic                  rstn,
  x68k_video_timing_gen_if.slave vif
);
  typedef struct packed {
    logic [HC_W-1:0] htotal, hsynl, hvbgn, hvend;
    logic [VC_W-1:0] vtotal, vsynl, vvbgn, vvend, rint;
    logic            interlace, dscan;
  } tmg_t;

  tmg_t                sh_q, sh_d, tin;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [ACC_W:0]      sum, diff;
  logic [DOT_LOG2-1:0] dot_q, dot_d;
  logic [HC_W-1:0]     hcnt_q, hcnt_d, char_idx;
  logic [VC_W-1:0]     vcnt_q, vcnt_d, src_line_q, src_line_d;
  logic [VC_W:0]       vlast;
  logic [LB_AW-1:0]    lbuf_addr_q, lbuf_addr_d;
  logic [LB_AW+HC_W+DOT_LOG2-1:0] la_ext;
  logic pix_ce_q, pix_ce_d, field_q, field_d, lbuf_sel_q, lbuf_sel_d;
  logic hsync_q, hsync_d, vsync_q, vsync_d, hblank_q, hblank_d, vblank_q, vblank_d;
  logic de_q, de_d, hcomp_q, hcomp_d, vcomp_q, vcomp_d, rint_irq_q, rint_irq_d;
  logic line_end, frame_end;

  always_comb begin
    tin = '{htotal: vif.htotal, hsynl: vif.hsynl, hvbgn: vif.hvbgn, hvend: vif.hvend,
            vtotal: vif.vtotal, vsynl: vif.vsynl, vvbgn: vif.vvbgn, vvend: vif.vvend,
            rint: vif.rint, interlace: vif.interlace, dscan: vif.dscan};
    sum      = {1'b0, acc_q} + {1'b0, vif.ce_inc};
    diff     = sum - {1'b0, vif.ce_mod};
    acc_d    = sum[ACC_W-1:0];
    pix_ce_d = 1'b0;
    if (sum >= {1'b0, vif.ce_mod}) begin
      acc_d    = diff[ACC_W-1:0];
      pix_ce_d = 1'b1;
    end

    dot_d     = dot_q;
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    field_d   = field_q;
    sh_d      = sh_q;
    line_end  = 1'b0;
    frame_end = 1'b0;
    // field 0 of an interlaced pair carries one extra line
    vlast = {1'b0, sh_q.vtotal} + (VC_W+1)'(sh_q.interlace & ~field_q);
    if (pix_ce_q) begin
      dot_d = dot_q + DOT_LOG2'(1);
      if (dot_q == '1) begin
        if (hcnt_q == sh_q.htotal) begin
          hcnt_d   = '0;
          line_end = 1'b1;
          if ({1'b0, vcnt_q} == vlast) begin
            vcnt_d    = '0;
            frame_end = 1'b1;
            field_d   = sh_q.interlace & ~field_q;
            sh_d      = tin;
          end else begin
            vcnt_d = vcnt_q + VC_W'(1);
          end
        end else begin
          hcnt_d = hcnt_q + HC_W'(1);
        end
      end
    end

    // decodes look at the post-update counters and shadows so new timing lands on line 0
    hsync_d    = hcnt_d < sh_d.hsynl;
    vsync_d    = vcnt_d < sh_d.vsynl;
    hblank_d   = ~((hcnt_d >= sh_d.hvbgn) && (hcnt_d < sh_d.hvend));
    vblank_d   = ~((vcnt_d >= sh_d.vvbgn) && (vcnt_d < sh_d.vvend));
    de_d       = ~hblank_d & ~vblank_d;
    char_idx   = hcnt_d - sh_d.hvbgn;
    la_ext     = {LB_AW'(0), char_idx, dot_d};
    lbuf_addr_d = hblank_d ? '0 : la_ext[LB_AW-1:0];
    hcomp_d    = line_end;
    vcomp_d    = frame_end;
    rint_irq_d = line_end && (vcnt_d == sh_d.rint);
    lbuf_sel_d = lbuf_sel_q ^ (line_end & (~sh_d.dscan | ~vcnt_d[0]));
    src_line_d = sh_d.dscan ? (vcnt_d >> 1) : vcnt_d;
  end

  always_ff @(posedge gclk) begin
    if (!rstn) begin
      sh_q        <= tin;
      acc_q       <= '0;
      pix_ce_q    <= 1'b0;
      dot_q       <= '0;
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      field_q     <= 1'b0;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      hblank_q    <= 1'b1;
      vblank_q    <= 1'b1;
      de_q        <= 1'b0;
      hcomp_q     <= 1'b0;
      vcomp_q     <= 1'b0;
      rint_irq_q  <= 1'b0;
      lbuf_sel_q  <= 1'b1;
      lbuf_addr_q <= '0;
      src_line_q  <= '0;
    end else begin
      sh_q        <= sh_d;
      acc_q       <= acc_d;
      pix_ce_q    <= pix_ce_d;
      dot_q       <= dot_d;
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      field_q     <= field_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      hblank_q    <= hblank_d;
      vblank_q    <= vblank_d;
      de_q        <= de_d;
      hcomp_q     <= hcomp_d;
      vcomp_q     <= vcomp_d;
      rint_irq_q  <= rint_irq_d;
      lbuf_sel_q  <= lbuf_sel_d;
      lbuf_addr_q <= lbuf_addr_d;
      src_line_q  <= src_line_d;
    end
  end

  assign vif.pix_ce    = pix_ce_q;
  assign vif.hsync     = hsync_q;
  assign vif.vsync     = vsync_q;
  assign vif.hblank    = hblank_q;
  assign vif.vblank    = vblank_q;
  assign vif.de        = de_q;
  assign vif.hcomp     = hcomp_q;
  assign vif.vcomp     = vcomp_q;
  assign vif.field     = field_q;
  assign vif.lbuf_sel  = lbuf_sel_q;
  assign vif.rint_irq  = rint_irq_q;
  assign vif.lbuf_addr = lbuf_addr_q;
  assign vif.src_line  = src_line_q;
endmodule

// File: tb/tb_x68k_video_timing_gen.sv
// Bench for x68k_video_timing_gen: a raster model based on line position checks every
// output each cycle, and directed scenarios pin periods and sequences with literal values.
module tb_x68k_video_timing_gen;
  logic gclk = 1'b0;
  logic rstn = 1'b0;
  always #5 gclk = ~gclk;

  x68k_video_timing_gen_if vif ();
  x68k_video_timing_gen dut (.gclk(gclk), .rstn(rstn), .vif(vif));

  int n_chk = 0, n_fail = 0;
  localparam logic [30:0] RST_VEC = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                     1'b0, 1'b1, 1'b0, 10'd0, 10'd0};

  // ---- model: raster position as a flat dot index within the line ----
  int m_acc, m_pos, m_v, cyc;
  logic m_valid = 1'b0, m_rst, m_pce, m_f, m_sel, m_hc, m_vc, m_irq;
  int sh_ht, sh_hs, sh_hb, sh_he, sh_vt, sh_vs, sh_vb, sh_ve, sh_ri;
  logic sh_il, sh_ds;
  longint sum;

  task automatic load_sh();
    sh_ht = int'(vif.htotal); sh_hs = int'(vif.hsynl); sh_hb = int'(vif.hvbgn); sh_he = int'(vif.hvend);
    sh_vt = int'(vif.vtotal); sh_vs = int'(vif.vsynl); sh_vb = int'(vif.vvbgn); sh_ve = int'(vif.vvend);
    sh_ri = int'(vif.rint); sh_il = vif.interlace; sh_ds = vif.dscan;
  endtask

  always @(posedge gclk) begin
    cyc++;
    if (!rstn) begin
      m_valid = 1'b1; m_rst = 1'b1; m_acc = 0; m_pce = 1'b0; m_pos = 0; m_v = 0;
      m_f = 1'b0; m_sel = 1'b1; m_hc = 1'b0; m_vc = 1'b0; m_irq = 1'b0;
      load_sh();
    end else begin
      m_rst = 1'b0; m_hc = 1'b0; m_vc = 1'b0; m_irq = 1'b0;
      if (m_pce) begin
        m_pos++;
        if (m_pos == (sh_ht + 1) * 8) begin
          m_pos = 0; m_hc = 1'b1;
          if (m_v == sh_vt + ((sh_il && !m_f) ? 1 : 0)) begin
            m_v = 0; m_vc = 1'b1; m_f = sh_il ? !m_f : 1'b0;
            load_sh();
          end else m_v++;
          m_irq = (m_v == sh_ri);
          if (!sh_ds || (m_v % 2 == 0)) m_sel = !m_sel;
        end
      end
      sum = longint'(m_acc) + longint'(vif.ce_inc);
      m_pce = (sum >= longint'(vif.ce_mod));
      m_acc = m_pce ? int'(sum - longint'(vif.ce_mod)) : int'(sum);
    end
  end

  function automatic logic [30:0] exp_vec();
    int hc, dt, addr, src;
    logic hs, vs, hb, vb;
    if (m_rst) return RST_VEC;
    hc = m_pos / 8; dt = m_pos % 8;
    hs = hc < sh_hs; vs = m_v < sh_vs;
    hb = !(hc >= sh_hb && hc < sh_he);
    vb = !(m_v >= sh_vb && m_v < sh_ve);
    addr = hb ? 0 : ((((hc - sh_hb) & 255) * 8 + dt) & 1023);
    src = sh_ds ? m_v / 2 : m_v;
    return {m_pce, hs, vs, hb, vb, !hb && !vb, m_hc, m_vc, m_f, m_sel, m_irq, 10'(addr), 10'(src)};
  endfunction

  function automatic logic [30:0] act_vec();
    return {vif.pix_ce, vif.hsync, vif.vsync, vif.hblank, vif.vblank, vif.de, vif.hcomp,
            vif.vcomp, vif.field, vif.lbuf_sel, vif.rint_irq, vif.lbuf_addr, vif.src_line};
  endfunction

  always @(posedge gclk) begin
    #1;
    if (m_valid) begin
      n_chk++;
      if (act_vec() !== exp_vec()) begin
        n_fail++;
        $display("FAIL raster cyc=%0d act=%h exp=%h", cyc, act_vec(), exp_vec());
      end
    end
  end

  // ---- directed helpers ----
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic cfg(input int ht, hs, hb, he, vt, vs, vb, ve, ri, input logic il, ds,
                     input int inc, md);
    vif.htotal = 8'(ht); vif.hsynl = 8'(hs); vif.hvbgn = 8'(hb); vif.hvend = 8'(he);
    vif.vtotal = 10'(vt); vif.vsynl = 10'(vs); vif.vvbgn = 10'(vb); vif.vvend = 10'(ve);
    vif.rint = 10'(ri); vif.interlace = il; vif.dscan = ds;
    vif.ce_inc = 24'(inc); vif.ce_mod = 24'(md);
  endtask

  task automatic do_reset();
    @(negedge gclk); rstn = 1'b0;
    @(negedge gclk);
    @(negedge gclk); rstn = 1'b1;
  endtask

  // waits for a pulse (0 hcomp, 1 vcomp, 2 rint_irq); n = gclk count, or -1 on timeout
  task automatic wait_sig(input int sel, input int maxc, output int n);
    logic hit;
    n = 0;
    do begin
      @(negedge gclk); n++;
      hit = (sel == 0) ? vif.hcomp : (sel == 1) ? vif.vcomp : vif.rint_irq;
    end while (!hit && n < maxc);
    if (!hit) begin
      n = -1;
      chk("wait_timeout", sel, -1);
    end
  endtask

  localparam int FAST_INC = 24'hFFFFFE, FAST_MOD = 24'hFFFFFF;

  initial begin
    int n, cnt, hb, hc, de, hs, mx, f, lines, irqs, a8, a23, a24;
    int src[6];
    logic sel[6];
    logic prev;
    cfg(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 12500, 28755);

    // 1: fractional CE density and spacing
    do_reset();
    cnt = 0; hb = 0; prev = 1'b0;
    for (int i = 0; i < 28755; i++) begin
      @(negedge gclk);
      if (vif.pix_ce) begin cnt++; if (prev) hb++; end
      prev = vif.pix_ce;
    end
    chk("ce_count", cnt, 12500);
    chk("ce_back_to_back", hb, 0);

    // 2: htotal=3 vtotal=2, CE nearly every gclk, degenerate blanking
    cfg(3, 0, 0, 0, 2, 0, 0, 0, 0, 1'b0, 1'b0, FAST_INC, FAST_MOD);
    do_reset();
    wait_sig(1, 500, n);
    cnt = 0; hb = 0; hc = 0;
    do begin
      @(negedge gclk); cnt++;
      if (!vif.hblank) hb++;
      if (vif.hcomp) hc++;
    end while (!vif.vcomp && cnt < 500);
    chk("frame_period", cnt, 96);
    chk("lines_per_frame", hc, 3);
    chk("degenerate_hblank_low", hb, 0);
    wait_sig(0, 200, n);
    chk("line_period", n, 32);

    // 3: hsync chars 0-1, DE chars 1-2, line-buffer address sweep
    cfg(4, 2, 1, 3, 2, 0, 0, 3, 0, 1'b0, 1'b0, FAST_INC, FAST_MOD);
    do_reset();
    wait_sig(0, 200, n);
    de = 0; hs = 0; mx = 0; a8 = -1; a23 = -1; a24 = -1;
    for (int i = 0; i < 40; i++) begin
      if (vif.de) de++;
      if (vif.hsync) hs++;
      if (int'(vif.lbuf_addr) > mx) mx = int'(vif.lbuf_addr);
      if (i == 8) a8 = int'(vif.lbuf_addr);
      if (i == 23) a23 = int'(vif.lbuf_addr);
      if (i == 24) a24 = int'(vif.lbuf_addr);
      @(negedge gclk);
    end
    chk("de_cycles", de, 16);
    chk("hsync_cycles", hs, 16);
    chk("lbuf_addr_max", mx, 15);
    chk("lbuf_addr_first", a8, 0);
    chk("lbuf_addr_last", a23, 15);
    chk("lbuf_addr_blank", a24, 0);
    chk("next_line_hcomp", int'(vif.hcomp), 1);

    // 4: interlace, vtotal=4, rint=2
    cfg(0, 1, 0, 1, 4, 1, 1, 4, 2, 1'b1, 1'b0, FAST_INC, FAST_MOD);
    do_reset();
    wait_sig(1, 500, n);
    for (int fr = 0; fr < 2; fr++) begin
      f = int'(vif.field); lines = 0; irqs = 0; cnt = 0;
      do begin
        @(negedge gclk); cnt++;
        if (vif.hcomp) lines++;
        if (vif.rint_irq) irqs++;
      end while (!vif.vcomp && cnt < 500);
      chk($sformatf("il_field_%0d", fr), f, (fr == 0) ? 1 : 0);
      chk($sformatf("il_lines_%0d", fr), lines, (fr == 0) ? 5 : 6);
      chk($sformatf("il_irqs_%0d", fr), irqs, 1);
    end

    // 5: doublescan source-line mapping and bank toggling
    cfg(0, 0, 0, 1, 5, 0, 0, 6, 0, 1'b0, 1'b1, FAST_INC, FAST_MOD);
    do_reset();
    wait_sig(1, 500, n);
    src[0] = int'(vif.src_line); sel[0] = vif.lbuf_sel;
    for (int k = 1; k < 6; k++) begin
      wait_sig(0, 100, n);
      src[k] = int'(vif.src_line); sel[k] = vif.lbuf_sel;
    end
    for (int k = 0; k < 6; k++) chk($sformatf("ds_src_%0d", k), src[k], k / 2);
    for (int k = 1; k < 6; k++)
      chk($sformatf("ds_sel_toggle_%0d", k), int'(sel[k] ^ sel[k-1]), (k % 2 == 0) ? 1 : 0);

    // 6: htotal change mid-frame waits for the frame boundary, then mid-line reset
    cfg(7, 1, 0, 4, 2, 1, 0, 2, 1, 1'b0, 1'b0, FAST_INC, FAST_MOD);
    do_reset();
    wait_sig(1, 1000, n);
    wait_sig(0, 200, n);
    chk("old_len_line1", n, 64);
    vif.htotal = 8'd3;
    wait_sig(0, 200, n);
    chk("old_len_line2", n, 64);
    wait_sig(1, 200, n);
    chk("old_len_to_vcomp", n, 64);
    wait_sig(0, 200, n);
    chk("new_len_line", n, 32);
    repeat (10) @(negedge gclk);
    rstn = 1'b0;
    @(negedge gclk);
    chk("midline_reset_vec", int'(act_vec()), int'(RST_VEC));
    rstn = 1'b1;
    repeat (50) @(negedge gclk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
